apb_slave_regfile: RTL and testbench

APB completer (slave) peripheral: a small memory-mapped register file that answers transfers driven by the AHB-to-APB bridge on the APB side. One instance sits on one bit of the bridge's `Pselx` bus. It decodes `Paddr`, performs reads and writes, and inserts a configurable number of wait states via `Pready`. It flags illegal accesses with `Pslverr`.

---
 rtl/apb_slave_regfile.sv | 69 ++++++
 tb/tb_apb_slave_regfile.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with six R/W registers, an ID register and a write counter.
module apb_slave_regfile #(
  parameter int          SEL_BIT     = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);
  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [31:0] addr_q, wdata_q, wcnt, a, rd;
  logic [31:0] regs [6];
  logic write_q, psel, setup, access, go_ready, wr, err;
  assign psel   = Pselx[SEL_BIT];
  assign setup  = psel & ~Penable;
  assign access = psel & Penable;
  always_comb begin
    state_nx = state == IDLE ? (setup ? (WAIT_CYCLES == 0 ? READY : WAIT) : IDLE) :
               state == WAIT ? (!access ? IDLE : cnt == 4'd1 ? READY : WAIT) : IDLE;
    go_ready = state_nx == READY;
    // With no wait states the response is built in the setup cycle, before the capture lands
    a  = state == IDLE ? Paddr : addr_q;
    wr = state == IDLE ? Pwrite : write_q;
    err = a[31:5] != BASE_ADDR[31:5] || a[1:0] != 2'b00 || (wr && a[4:3] == 2'b11);
    rd = a[4:2] == 3'd6 ? ID_VALUE : a[4:2] == 3'd7 ? wcnt : regs[a[4:2]];
  end
  always_ff @(posedge Hclk or negedge Hresetn)
    if (!Hresetn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      wcnt    <= '0;
      Prdata  <= '0;
      Pready  <= 1'b0;
      Pslverr <= 1'b0;
      for (int i = 0; i < 6; i++) regs[i] <= '0;
    end else begin
      if (state == IDLE && setup) begin
        addr_q  <= Paddr;
        wdata_q <= Pwdata;
        write_q <= Pwrite;
        cnt     <= 4'(WAIT_CYCLES);
      end else if (state == WAIT && access) cnt <= cnt - 4'd1;
      Pready  <= go_ready;
      Pslverr <= go_ready & err;
      Prdata  <= go_ready && !wr && !err ? rd : '0;
      // Pslverr still holds this transfer's error flag during READY
      if (state == READY && write_q && !Pslverr) begin
        if (addr_q[4:2] < 3'd6) regs[addr_q[4:2]] <= wdata_q;
        wcnt <= wcnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: two instances (no-wait on Pselx[0], 3-wait on Pselx[1]) against a spec-level model.
module tb_apb_slave_regfile;
  logic        Hclk = 1'b0, Hresetn = 1'b0, Penable = 1'b0, Pwrite = 1'b0;
  logic [2:0]  Pselx = 3'b000;
  logic [31:0] Paddr = '0, Pwdata = '0;
  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1, slverr0, slverr1;
  int errors = 0, checks = 0;
  logic [31:0] mregs [2][6];
  logic [31:0] mwcnt [2];
  localparam logic [31:0] BASE = 32'h8000_0000, ID = 32'hA9B0_0001;

  apb_slave_regfile #(.SEL_BIT(0), .WAIT_CYCLES(0)) dut0 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(rdata0), .Pready(ready0), .Pslverr(slverr0));
  apb_slave_regfile #(.SEL_BIT(1), .WAIT_CYCLES(3)) dut1 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(rdata1), .Pready(ready1), .Pslverr(slverr1));

  always #5 Hclk = ~Hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int d);
    return d == 0 ? ready0 : ready1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mwcnt[d] = 0;
      for (int i = 0; i < 6; i++) mregs[d][i] = 0;
    end
  endtask

  task automatic go_idle();
    @(posedge Hclk); #1;
    Pselx = 3'b000; Penable = 1'b0;
  endtask

  // One full transfer on instance d; the model decides error, data and commit from the address alone
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int k, off;
    logic e;
    logic [31:0] er;
    off = (addr % 32) / 4;
    e = (addr / 32) != (BASE / 32) || (addr % 4) != 0 || (wr && off >= 6);
    er = (e || wr) ? 32'h0 : off < 6 ? mregs[d][off] : off == 6 ? ID : mwcnt[d];
    @(posedge Hclk); #1;
    Pselx = 3'(1 << d); Penable = 1'b0; Pwrite = wr; Paddr = addr; Pwdata = data;
    @(negedge Hclk);
    chk("setup_ready", {31'b0, rdy(d)}, 32'h0);
    @(posedge Hclk); #1;
    Penable = 1'b1; Paddr = $urandom; Pwdata = $urandom;
    k = 0;
    while (1) begin
      @(negedge Hclk);
      chk("unselected_ready", {31'b0, rdy(1 - d)}, 32'h0);
      if (rdy(d) || k >= 20) break;
      k++;
      @(posedge Hclk); #1;
    end
    chk(d == 0 ? "latency0" : "latency1", 32'(k), d == 0 ? 32'd0 : 32'd3);
    chk("slverr", {31'b0, d == 0 ? slverr0 : slverr1}, {31'b0, e});
    chk("rdata", d == 0 ? rdata0 : rdata1, er);
    if (rdy(d) && wr && !e) begin
      mregs[d][off] = data;
      mwcnt[d] = mwcnt[d] + 1;
    end
  endtask

  initial begin
    model_reset();
    @(posedge Hclk); @(negedge Hclk);
    chk("rst_ready0", {31'b0, ready0}, 32'h0);
    chk("rst_slverr0", {31'b0, slverr0}, 32'h0);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_ready1", {31'b0, ready1}, 32'h0);
    Hresetn = 1'b1;
    for (int i = 0; i < 8; i++) xfer(0, 1'b0, BASE + 32'(i * 4), 0);
    for (int i = 0; i < 8; i++) xfer(1, 1'b0, BASE + 32'(i * 4), 0);
    xfer(0, 1'b1, 32'h8000_000C, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'h8000_000C, 0);
    xfer(0, 1'b0, 32'h8000_001C, 0);
    chk("wcnt_after_write", mwcnt[0], 32'd1);
    xfer(0, 1'b1, 32'h8000_0018, 32'h1234_5678);
    xfer(0, 1'b1, 32'h9000_0000, 32'h1111_1111);
    xfer(0, 1'b0, 32'h8000_0002, 0);
    xfer(0, 1'b1, 32'h8000_001C, 32'h5);
    for (int i = 0; i < 8; i++) xfer(0, 1'b0, BASE + 32'(i * 4), 0);
    xfer(1, 1'b1, 32'h8000_0000, 32'h0BAD_F00D);
    xfer(1, 1'b0, 32'h8000_0000, 0);
    go_idle();
    // Abort: Penable drops in the second wait cycle
    @(posedge Hclk); #1;
    Pselx = 3'b010; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h8000_0008; Pwdata = 32'h7777_7777;
    @(posedge Hclk); #1; Penable = 1'b1;
    @(posedge Hclk); #1; Penable = 1'b0;
    @(posedge Hclk); #1; Pselx = 3'b000;
    for (int i = 0; i < 5; i++) begin
      @(negedge Hclk);
      chk("abort_ready", {31'b0, ready1}, 32'h0);
    end
    xfer(1, 1'b0, 32'h8000_0008, 0);
    xfer(1, 1'b0, 32'h8000_001C, 0);
    go_idle();
    // Access phase with no setup, and a select bit owned by neither instance
    @(posedge Hclk); #1; Pselx = 3'b011; Penable = 1'b1; Pwrite = 1'b1; Paddr = BASE;
    @(posedge Hclk); #1; Pselx = 3'b100; Penable = 1'b0;
    @(posedge Hclk); #1; Penable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Hclk);
      chk("stray_ready", {31'b0, ready0 | ready1}, 32'h0);
    end
    go_idle();
    xfer(0, 1'b0, BASE, 0);
    go_idle();
    // Counter wrap
    @(posedge Hclk); #1; force dut0.wcnt = 32'hFFFF_FFFF;
    @(negedge Hclk); release dut0.wcnt;
    mwcnt[0] = 32'hFFFF_FFFF;
    xfer(0, 1'b0, 32'h8000_001C, 0);
    xfer(0, 1'b1, 32'h8000_0014, 32'hA5A5_5A5A);
    xfer(0, 1'b0, 32'h8000_001C, 0);
    chk("wcnt_wrapped", mwcnt[0], 32'h0);
    // Random traffic on both instances
    for (int n = 0; n < 60; n++) begin
      int d, r, off;
      logic [31:0] addr;
      d = $urandom_range(1);
      r = $urandom_range(15);
      off = $urandom_range(7);
      addr = r == 0 ? $urandom : r == 1 ? BASE + 32'(off * 4) + 32'($urandom_range(3, 1)) : BASE + 32'(off * 4);
      xfer(d, 1'($urandom_range(1)), addr, $urandom);
    end
    // Reset asserted while Pready is high clears outputs without waiting for a clock
    xfer(0, 1'b0, 32'h8000_0018, 0);
    #1 Hresetn = 1'b0;
    #1;
    chk("async_ready", {31'b0, ready0}, 32'h0);
    chk("async_rdata", rdata0, 32'h0);
    Pselx = 3'b000; Penable = 1'b0;
    @(negedge Hclk); Hresetn = 1'b1;
    model_reset();
    // Reset during the wait state of a write to REG1
    @(posedge Hclk); #1;
    Pselx = 3'b010; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h8000_0004; Pwdata = 32'hCAFE_CAFE;
    @(posedge Hclk); #1; Penable = 1'b1;
    @(negedge Hclk); #2 Hresetn = 1'b0;
    #1;
    chk("wait_rst_ready", {31'b0, ready1}, 32'h0);
    chk("wait_rst_slverr", {31'b0, slverr1}, 32'h0);
    Pselx = 3'b000; Penable = 1'b0;
    @(negedge Hclk); Hresetn = 1'b1;
    xfer(1, 1'b0, 32'h8000_0004, 0);
    xfer(1, 1'b0, 32'h8000_001C, 0);
    go_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
